// File: rtl/multipath_pkg.sv
// Shared types, constants and helpers for the multipath channel emulator.
package multipath_pkg;

   typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_e;

   localparam int          LFSR_W       = 16;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam int          LFSR_TAP_A   = 15;
   localparam int          LFSR_TAP_B   = 13;
   localparam int          LFSR_TAP_C   = 12;
   localparam int          LFSR_TAP_D   = 10;

   // Ceiling log2 for elaboration-time width arithmetic (clog2(1) = 0).
   function automatic int clog2(input int unsigned v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   // Clamp a wide signed value into the range of a w-bit signed number.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int               w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/multipath_channel_p_delay_line.sv
// Circular symbol buffer: cleared on reset, one write port, one combinational
// read at a symbol offset behind the most recently written entry.
module multipath_channel_p_delay_line #(
   parameter int SYM_W = 2,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    we_i,
   input  logic signed [SYM_W-1:0] wdata_i,
   input  logic        [AW-1:0]    rd_delay_i,
   output logic signed [SYM_W-1:0] rdata_o
);

   logic signed [SYM_W-1:0] mem_q [DEPTH];
   logic        [AW-1:0]    wr_ptr_q;
   logic        [AW-1:0]    rd_addr;

   // Offset 0 addresses the entry written last; AW-bit arithmetic wraps mod DEPTH.
   always_comb begin
      rd_addr = wr_ptr_q - AW'(1) - rd_delay_i;
      rdata_o = mem_q[rd_addr];
   end

   // Store the symbol and advance the write pointer; reset clears every entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
      end else if (we_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
         wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
   end

endmodule

// File: rtl/multipath_channel_p.sv
// Multipath channel emulator: per accepted symbol, sums NTAPS delayed, scaled
// and attenuated copies of the symbol stream, optionally adds LFSR noise and
// presents one saturated sample with a single-cycle valid strobe.
module multipath_channel_p
   import multipath_pkg::*;
#(
   parameter  int          SYM_W   = 2,
   parameter  int          OUT_W   = 14,
   parameter  int          DEPTH   = 16,
   parameter  int          NTAPS   = 2,
   parameter  int          AMP     = 436,
   parameter  int          NOISE_W = 8,
   parameter  logic [15:0] SEED    = DEFAULT_SEED,
   localparam int          AW      = clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    sym_valid,
   input  logic signed [SYM_W-1:0] sym_in,
   input  logic [NTAPS*AW-1:0]     tap_delay,
   input  logic [NTAPS*4-1:0]      tap_shift,
   input  logic                    noise_en,
   output logic                    busy,
   output logic                    out_valid,
   output logic signed [OUT_W-1:0] chan_out,
   output logic                    overrun
);

   localparam int PW    = SYM_W + OUT_W;
   localparam int KW    = (NTAPS > 1) ? clog2(NTAPS) : 1;
   localparam int ACC_W = PW + clog2(NTAPS) + 1;
   localparam int SUM_W = ACC_W + 1;
   localparam logic signed [OUT_W-1:0] AMP_S = OUT_W'(AMP);

   state_e                    state_q, state_d;
   logic        [KW-1:0]      k_q, k_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic        [LFSR_W-1:0]  lfsr_q, lfsr_d;
   logic                      overrun_q, overrun_d;
   logic                      out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0]   chan_q, chan_d;
   logic        [NTAPS*AW-1:0] tap_delay_q;
   logic        [NTAPS*4-1:0] tap_shift_q;
   logic                      noise_en_q;

   logic                      accept;
   logic        [AW-1:0]      rd_delay;
   logic        [3:0]         rd_shift;
   logic signed [SYM_W-1:0]   rd_sym;
   logic signed [PW-1:0]      prod;
   logic signed [PW-1:0]      term;
   logic signed [SUM_W-1:0]   noise_ext;
   logic signed [SUM_W-1:0]   sum;
   logic                      lfsr_fb;

   assign accept    = sym_valid && (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign chan_out  = chan_q;
   assign overrun   = overrun_q;

   multipath_channel_p_delay_line #(
      .SYM_W (SYM_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_delay_line (
      .clk_i      (clk),
      .rst_ni     (reset),
      .we_i       (accept),
      .wdata_i    (sym_in),
      .rd_delay_i (rd_delay),
      .rdata_o    (rd_sym)
   );

   // Datapath for the current tap, the noise term and the pre-saturation sum.
   always_comb begin
      rd_delay  = tap_delay_q[k_q*AW +: AW];
      rd_shift  = tap_shift_q[k_q*4 +: 4];
      prod      = PW'(rd_sym) * PW'(AMP_S);
      term      = prod >>> rd_shift;
      noise_ext = noise_en_q ? {{(SUM_W-NOISE_W){lfsr_q[NOISE_W-1]}}, lfsr_q[NOISE_W-1:0]}
                             : '0;
      sum       = {acc_q[ACC_W-1], acc_q} + noise_ext;
      lfsr_fb   = lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B] ^
                  lfsr_q[LFSR_TAP_C] ^ lfsr_q[LFSR_TAP_D];
   end

   // Next-state logic: accept, accumulate one tap per cycle, then publish.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      acc_d       = acc_q;
      lfsr_d      = lfsr_q;
      overrun_d   = overrun_q;
      out_valid_d = 1'b0;
      chan_d      = chan_q;
      if (sym_valid && (state_q != IDLE)) overrun_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (sym_valid) begin
               state_d = ACCUM;
               k_d     = '0;
               acc_d   = '0;
               lfsr_d  = {lfsr_q[LFSR_W-2:0], lfsr_fb};
            end
         end
         ACCUM: begin
            acc_d = acc_q + {{(ACC_W-PW){term[PW-1]}}, term};
            if (k_q == KW'(NTAPS - 1)) state_d = FINISH;
            else                       k_d     = k_q + KW'(1);
         end
         FINISH: begin
            chan_d      = OUT_W'(saturate({{(64-SUM_W){sum[SUM_W-1]}}, sum}, OUT_W));
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and output registers, returned to their idle values by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         k_q         <= '0;
         lfsr_q      <= SEED;
         overrun_q   <= 1'b0;
         out_valid_q <= 1'b0;
         chan_q      <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         lfsr_q      <= lfsr_d;
         overrun_q   <= overrun_d;
         out_valid_q <= out_valid_d;
         chan_q      <= chan_d;
      end
   end

   // Accumulator and per-symbol configuration snapshot (cleared/loaded on accept).
   always_ff @(posedge clk) begin
      acc_q <= acc_d;
      if (accept) begin
         tap_delay_q <= tap_delay;
         tap_shift_q <= tap_shift;
         noise_en_q  <= noise_en;
      end
   end

endmodule

// File: tb/tb_multipath_channel_p.sv
module tb_multipath_channel_p;

   typedef struct {
      logic signed [1:0] sym;
      int                exp;
   } vec_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              sym_valid;
   logic signed [1:0] sym_in;
   logic [7:0]        tap_delay, tap_delay2;
   logic [7:0]        tap_shift, tap_shift2;
   logic              noise_en;
   logic              busy, out_valid, overrun;
   logic signed [13:0] chan_out;
   logic              busy2, out_valid2, overrun2;
   logic signed [13:0] chan_out2;

   int compared   = 0;
   int mismatched = 0;

   vec_t tbl [33];

   always #5 clk = ~clk;

   multipath_channel_p dut (
      .clk       (clk),
      .reset     (reset),
      .sym_valid (sym_valid),
      .sym_in    (sym_in),
      .tap_delay (tap_delay),
      .tap_shift (tap_shift),
      .noise_en  (noise_en),
      .busy      (busy),
      .out_valid (out_valid),
      .chan_out  (chan_out),
      .overrun   (overrun)
   );

   multipath_channel_p #(.AMP(8191)) dut_sat (
      .clk       (clk),
      .reset     (reset),
      .sym_valid (sym_valid),
      .sym_in    (sym_in),
      .tap_delay (tap_delay2),
      .tap_shift (tap_shift2),
      .noise_en  (noise_en),
      .busy      (busy2),
      .out_valid (out_valid2),
      .chan_out  (chan_out2),
      .overrun   (overrun2)
   );

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
   endtask

   // Present one symbol, wait (bounded) for out_valid, return both DUT samples.
   task automatic send(input logic signed [1:0] s, output int r1, output int r2);
      int lat;
      sym_valid = 1'b1;
      sym_in    = s;
      step();
      sym_valid = 1'b0;
      sym_in    = '0;
      lat       = 0;
      while (!out_valid && lat < 10) begin
         step();
         lat++;
      end
      chk("latency", lat, 3);
      r1 = chan_out;
      r2 = chan_out2;
   endtask

   initial begin
      int r1, r2, lat, pulses, s, e;
      int hist[$];
      logic signed [1:0] sv;

      reset      = 1'b0;
      sym_valid  = 1'b0;
      sym_in     = '0;
      tap_delay  = {4'd6, 4'd0};
      tap_shift  = {4'd1, 4'd0};
      tap_delay2 = '0;
      tap_shift2 = '0;
      noise_en   = 1'b0;

      for (int i = 0; i < 33; i++) begin
         tbl[i].sym = 2'sb00;
         tbl[i].exp = 0;
      end
      tbl[0].sym  = 2'sb01; tbl[0].exp  = 436;
      tbl[6].exp  = 218;
      tbl[10].sym = 2'sb11; tbl[10].exp = -436;
      tbl[16].exp = -218;
      tbl[20].sym = 2'sb01; tbl[20].exp = 436;
      tbl[26].sym = 2'sb11; tbl[26].exp = -218;
      tbl[32].exp = -218;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      step();
      chk("rst_chan_out", chan_out, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);

      // Busy during processing, then impulse / echo table
      sym_valid = 1'b1;
      sym_in    = tbl[0].sym;
      step();
      sym_valid = 1'b0;
      sym_in    = '0;
      chk("busy_after_accept", busy, 1);
      lat = 0;
      while (!out_valid && lat < 10) begin
         step();
         lat++;
      end
      chk("first_latency", lat, 3);
      chk("busy_in_out_valid", busy, 0);
      chk("impulse_0", chan_out, tbl[0].exp);
      chk("sat_0", chan_out2, 8191);
      for (int i = 1; i < 33; i++) begin
         send(tbl[i].sym, r1, r2);
         chk($sformatf("impulse_%0d", i), r1, tbl[i].exp);
         e = (tbl[i].sym == 2'sb01) ? 8191 : (tbl[i].sym == 2'sb11) ? -8192 : 0;
         chk($sformatf("sat_%0d", i), r2, e);
      end

      // Wrap: random symbols, echo tap at DEPTH-1
      do_reset();
      tap_delay = {4'd15, 4'd0};
      for (int n = 0; n < 40; n++) begin
         s  = int'($urandom_range(2)) - 1;
         sv = 2'(s);
         hist.push_back(s);
         send(sv, r1, r2);
         e = 436 * s + ((n >= 15) ? ((436 * hist[n-15]) >>> 1) : 0);
         chk($sformatf("wrap_%0d", n), r1, e);
      end

      // Overrun: second strobe while busy is dropped and flagged
      do_reset();
      tap_delay = {4'd6, 4'd0};
      sym_valid = 1'b1;
      sym_in    = 2'sb01;
      step();
      sym_in    = 2'sb11;
      step();
      sym_valid = 1'b0;
      sym_in    = '0;
      chk("overrun_set", overrun, 1);
      lat = 1;
      while (!out_valid && lat < 10) begin
         step();
         lat++;
      end
      chk("overrun_latency", lat, 3);
      chk("overrun_chan", chan_out, 436);
      for (int n = 1; n < 6; n++) begin
         send(2'sb00, r1, r2);
         chk("overrun_zero", r1, 0);
      end
      send(2'sb00, r1, r2);
      chk("overrun_echo", r1, 218);
      chk("overrun_sticky", overrun, 1);

      // Reset asserted mid-ACCUM
      do_reset();
      chk("overrun_cleared", overrun, 0);
      tap_delay = {4'd15, 4'd0};
      send(2'sb00, r1, r2);
      chk("pre_rst_0", r1, 0);
      send(2'sb01, r1, r2);
      chk("pre_rst_1", r1, 436);
      sym_valid = 1'b1;
      sym_in    = 2'sb00;
      step();
      sym_valid = 1'b0;
      step();
      reset = 1'b0;
      #1;
      chk("midrst_chan_out", chan_out, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_busy", busy, 0);
      step();
      reset  = 1'b1;
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (out_valid) pulses++;
      end
      chk("midrst_no_valid", pulses, 0);
      send(2'sb00, r1, r2);
      chk("midrst_echo_cleared", r1, 0);

      // Noise from the LFSR
      do_reset();
      tap_delay = {4'd6, 4'd0};
      noise_en  = 1'b1;
      send(2'sb00, r1, r2);
      chk("noise_0", r1, -61);
      send(2'sb00, r1, r2);
      chk("noise_1", r1, -121);
      noise_en = 1'b0;
      send(2'sb00, r1, r2);
      chk("noise_off", r1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
